// File: rtl/alu_bist.sv
// Built-in self-test initiator that drives operands and op codes into the
// datapath ALU and checks result/zero against a golden model.
// Ports: clk, reset_n, start | alu_srcA/B, alu_cntrl -> ALU, alu_out/zero <- ALU
//        busy, done, pass, err_count, fail_vec, fail_op status.
module alu_bist #(
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'hACE12357
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [31:0] alu_srcA,
  output logic [31:0] alu_srcB,
  output logic [2:0]  alu_cntrl,
  input  logic [31:0] alu_out,
  input  logic        alu_zero,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [15:0] fail_vec,
  output logic [2:0]  fail_op
);

  localparam logic [31:0] TAPS   = 32'h80200003;
  localparam logic [31:0] SEED_B = SEED ^ 32'h5A5A5A5A;
  localparam logic [15:0] LAST   = 16'(NUM_VECTORS - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] vec_idx;
  logic [31:0] lfsr_a;
  logic [31:0] lfsr_b;

  logic [31:0] diff;
  logic [31:0] expected;
  logic        mismatch;
  logic [15:0] err_next;
  logic [15:0] vec_next;
  logic [2:0]  op_next;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] x
  );
    lfsr_step = x[0] ? ((x >> 1) ^ TAPS) : (x >> 1);
  endfunction

  always_comb begin
    diff = alu_srcA - alu_srcB;
    expected = '0;
    case (alu_cntrl)
      OP_ADD:  expected = alu_srcA + alu_srcB;
      OP_SUB:  expected = diff;
      OP_AND:  expected = alu_srcA & alu_srcB;
      OP_OR:   expected = alu_srcA | alu_srcB;
      // sign of the wrapped difference, as the datapath ALU defines slt
      OP_SLT:  expected = {31'b0, diff[31]};
      default: expected = '0;
    endcase
  end

  always_comb begin
    mismatch = (alu_out != expected)
             || (alu_zero != (expected == '0));
    err_next = err_count;
    if (mismatch && err_count != 16'hFFFF)
      err_next = err_count + 16'd1;
    vec_next = vec_idx + 16'd1;
  end

  always_comb begin
    op_next = OP_ADD;
    case (alu_cntrl)
      OP_ADD:  op_next = OP_SUB;
      OP_SUB:  op_next = OP_AND;
      OP_AND:  op_next = OP_OR;
      OP_OR:   op_next = OP_SLT;
      default: op_next = OP_ADD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      vec_idx   <= '0;
      lfsr_a    <= SEED;
      lfsr_b    <= SEED_B;
      alu_srcA  <= '0;
      alu_srcB  <= '0;
      alu_cntrl <= OP_ADD;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_op   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_DRIVE;
            vec_idx   <= '0;
            lfsr_a    <= SEED;
            lfsr_b    <= SEED_B;
            alu_srcA  <= '0;
            alu_srcB  <= '0;
            alu_cntrl <= OP_ADD;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_op   <= '0;
          end
        end
        S_DRIVE: begin
          state <= S_CHECK;
        end
        S_CHECK: begin
          err_count <= err_next;
          if (mismatch && err_count == '0) begin
            fail_vec <= vec_idx;
            fail_op  <= alu_cntrl;
          end
          if (alu_cntrl != OP_SLT) begin
            alu_cntrl <= op_next;
            state     <= S_DRIVE;
          end else if (vec_idx == LAST) begin
            state     <= S_DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (err_next == '0);
            alu_srcA  <= '0;
            alu_srcB  <= '0;
            alu_cntrl <= OP_ADD;
          end else begin
            state     <= S_DRIVE;
            vec_idx   <= vec_next;
            alu_cntrl <= OP_ADD;
            if (vec_next == 16'd1) begin
              alu_srcA <= 32'h7FFFFFFF;
              alu_srcB <= 32'h80000000;
            end else if (vec_next == 16'd2) begin
              alu_srcA <= 32'h80000000;
              alu_srcB <= 32'h00000001;
            end else begin
              // first random vector uses the seeds, then each LFSR steps
              alu_srcA <= lfsr_a;
              alu_srcB <= lfsr_b;
              lfsr_a   <= lfsr_step(lfsr_a);
              lfsr_b   <= lfsr_step(lfsr_b);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist.sv
// Self-checking bench for alu_bist: drives a behavioural ALU with optional
// faults and checks operand schedule, run length and final status.
module tb_alu_bist;

  localparam int N = 4;
  localparam int OPS = 5 * N;
  localparam logic [31:0] SEED = 32'hACE12357;
  localparam logic [31:0] TAPS = 32'h80200003;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] alu_srcA, alu_srcB, alu_out;
  logic [2:0]  alu_cntrl, fail_op;
  logic        alu_zero, busy, done, pass;
  logic [15:0] err_count, fail_vec;

  int n_chk = 0;
  int n_fail = 0;
  int mode = 0;
  int run_mode = 0;
  bit aborted = 1'b0;
  int idx = 0;

  logic [31:0] ea [OPS];
  logic [31:0] eb [OPS];
  logic [2:0]  eo [OPS];
  logic [31:0] cap [OPS];
  logic [31:0] ref_cap [OPS];

  alu_bist #(.NUM_VECTORS(N), .SEED(SEED)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_cntrl(alu_cntrl), .alu_out(alu_out),
    .alu_zero(alu_zero), .busy(busy), .done(done),
    .pass(pass), .err_count(err_count),
    .fail_vec(fail_vec), .fail_op(fail_op)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] gold(
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] op
  );
    logic [31:0] d;
    d = a - b;
    case (op)
      3'b000:  return a + b;
      3'b001:  return d;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b101:  return {31'b0, d[31]};
      default: return 32'h0;
    endcase
  endfunction

  // ALU under test, with injectable faults
  always_comb begin
    alu_out = gold(alu_srcA, alu_srcB, alu_cntrl);
    if (mode == 1 && alu_cntrl == 3'b101) alu_out = '0;
    alu_zero = (alu_out == '0);
    if (mode == 2) alu_zero = 1'b0;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic build_model();
    logic [31:0] la, lb, a, b;
    logic [2:0] ops [5];
    ops[0] = 3'b000; ops[1] = 3'b001; ops[2] = 3'b010;
    ops[3] = 3'b011; ops[4] = 3'b101;
    la = SEED;
    lb = SEED ^ 32'h5A5A5A5A;
    for (int v = 0; v < N; v++) begin
      if (v == 0) begin a = 0; b = 0; end
      else if (v == 1) begin a = 32'h7FFFFFFF; b = 32'h80000000; end
      else if (v == 2) begin a = 32'h80000000; b = 32'h1; end
      else begin
        a = la; b = lb;
        la = {1'b0, la[31:1]} ^ (la[0] ? TAPS : 32'h0);
        lb = {1'b0, lb[31:1]} ^ (lb[0] ? TAPS : 32'h0);
      end
      for (int k = 0; k < 5; k++) begin
        ea[5*v+k] = a; eb[5*v+k] = b; eo[5*v+k] = ops[k];
      end
    end
  endtask

  task automatic model_run(input int m, output int errs,
                           output int fv, output int fo);
    logic [31:0] r, o;
    logic z;
    errs = 0; fv = 0; fo = 0;
    for (int i = 0; i < OPS; i++) begin
      r = gold(ea[i], eb[i], eo[i]);
      o = (m == 1 && eo[i] == 3'b101) ? 32'h0 : r;
      z = (m == 2) ? 1'b0 : (o == 0);
      if (o != r || z != (r == 0)) begin
        if (errs == 0) begin fv = i / 5; fo = int'(eo[i]); end
        errs++;
      end
    end
  endtask

  always @(negedge clk) begin
    int e, fv, fo;
    if (busy) begin
      if (idx == 0) begin run_mode = mode; aborted = 1'b0; end
      chk("done_low_busy", {31'b0, done}, 32'h0);
      if (idx < 2 * OPS) begin
        chk("srcA", alu_srcA, ea[idx >> 1]);
        chk("srcB", alu_srcB, eb[idx >> 1]);
        chk("cntrl", {29'b0, alu_cntrl}, {29'b0, eo[idx >> 1]});
        cap[idx >> 1] = alu_out;
      end else begin
        chk("busy_overrun", idx, 2 * OPS - 1);
      end
      idx++;
    end else begin
      if (idx != 0 && !aborted) chk("busy_len", idx, 10 * N);
      idx = 0;
      chk("idle_srcA", alu_srcA, 32'h0);
      chk("idle_srcB", alu_srcB, 32'h0);
      chk("idle_cntrl", {29'b0, alu_cntrl}, 32'h0);
      if (done) begin
        model_run(run_mode, e, fv, fo);
        chk("pass", {31'b0, pass}, {31'b0, e == 0});
        chk("err_count", {16'b0, err_count}, e);
        chk("fail_vec", {16'b0, fail_vec}, fv);
        chk("fail_op", {29'b0, fail_op}, fo);
      end
    end
  end

  task automatic run(input int m, input bit poke);
    @(negedge clk);
    mode = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (poke) begin
      repeat (5) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 200 && !done; i++) @(negedge clk);
    chk("done_seen", {31'b0, done}, 32'h1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_srcA", alu_srcA, 32'h0);
    chk("rst_srcB", alu_srcB, 32'h0);
    chk("rst_cntrl", {29'b0, alu_cntrl}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_done", {31'b0, done}, 32'h0);
    chk("rst_pass", {31'b0, pass}, 32'h0);
    chk("rst_err", {16'b0, err_count}, 32'h0);
    chk("rst_fvec", {16'b0, fail_vec}, 32'h0);
    chk("rst_fop", {29'b0, fail_op}, 32'h0);
  endtask

  initial begin
    build_model();
    repeat (3) @(negedge clk);
    chk_reset_vals();
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'h0);

    // clean run with corner-vector literals
    run(0, 1'b0);
    chk("v1_sub", cap[6], 32'hFFFFFFFF);
    chk("v1_slt", cap[9], 32'h1);
    chk("v2_sub", cap[11], 32'h7FFFFFFF);
    chk("v2_slt", cap[14], 32'h0);
    chk("clean_pass", {31'b0, pass}, 32'h1);
    chk("clean_err", {16'b0, err_count}, 32'h0);
    for (int i = 0; i < OPS; i++) ref_cap[i] = cap[i];

    // slt stuck at 0
    run(1, 1'b0);
    chk("slt_pass", {31'b0, pass}, 32'h0);
    chk("slt_err_nz", {31'b0, err_count != 0}, 32'h1);
    chk("slt_fvec", {16'b0, fail_vec}, 32'h1);
    chk("slt_fop", {29'b0, fail_op}, 32'h5);

    // zero flag stuck at 0
    run(2, 1'b0);
    chk("zero_fvec", {16'b0, fail_vec}, 32'h0);
    chk("zero_fop", {29'b0, fail_op}, 32'h0);
    chk("zero_err_ge8", {31'b0, err_count >= 8}, 32'h1);

    // restart from DONE, with a start poke mid-run
    run(0, 1'b1);
    for (int i = 0; i < OPS; i++)
      chk("restart_same", cap[i], ref_cap[i]);

    // asynchronous reset in the middle of DRIVE
    @(negedge clk);
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_busy", {31'b0, busy}, 32'h1);
    chk("mid_cntrl", {29'b0, alu_cntrl}, 32'h1);
    aborted = 1'b1;
    #2 reset_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_done", {31'b0, done}, 32'h0);

    // run after reset must replay the seeded sequence
    run(0, 1'b0);
    chk("final_pass", {31'b0, pass}, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
